// File: rtl/seg_pkg.sv
// Shared seven-segment definitions for the hex display scanner.
// Holds the segment bit order, the blank pattern, and the 16-entry
// active-low hex glyph table. A segment bit of 0 means that segment is lit.
package seg_pkg;

    // seg_n[6:0] = {g, f, e, d, c, b, a}
    typedef enum int {
        SEG_A = 0,
        SEG_B = 1,
        SEG_C = 2,
        SEG_D = 3,
        SEG_E = 4,
        SEG_F = 5,
        SEG_G = 6
    } seg_bit_e;

    localparam int SEG_W = 7;

    typedef logic [SEG_W-1:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    localparam seg_t GLYPH_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic seg_t hex_glyph(input logic [3:0] nibble);
        return GLYPH_TABLE[nibble];
    endfunction

endpackage

// File: rtl/hex_display_scanner_if.sv
// Bus bundle between a display client and hex_display_scanner.
// Ports:
//   load        snapshot strobe
//   value       4*NUM_DIGITS bits to display; nibble 0 is the rightmost digit
//   dp_mask     per-digit decimal-point request (1 = lit)
//   blank_en    leading-zero blanking enable, used live
//   seg_n       active-low segments {g,f,e,d,c,b,a}
//   dp_n        active-low decimal point
//   an          one-hot digit enable
//   frame_done  one-cycle pulse per completed scan
interface hex_display_scanner_if #(
    parameter int NUM_DIGITS = 8
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_mask;
    logic                    blank_en;
    logic [6:0]              seg_n;
    logic                    dp_n;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_done;

    modport master (
        output load, value, dp_mask, blank_en,
        input  seg_n, dp_n, an, frame_done
    );

    modport slave (
        input  load, value, dp_mask, blank_en,
        output seg_n, dp_n, an, frame_done
    );
endinterface

// File: rtl/seg7_hex_lut.sv
// Combinational hex-nibble to active-low seven-segment decoder.
// Ports:
//   nibble  4-bit hex digit
//   seg_n   active-low segments {g,f,e,d,c,b,a}
module seg7_hex_lut
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg_n
);

    always_comb begin
        seg_n = hex_glyph(nibble);
    end

endmodule

// File: rtl/hex_display_scanner.sv
// Multiplexed hex display scanner. Snapshots a value on load, walks one
// digit per REFRESH_DIV clocks, and drives registered segment, decimal-point
// and anode outputs for the digit being scanned. Leading zeros above digit 0
// can be blanked with blank_en.
// Ports:
//   clk      system clock, rising edge
//   reset_n  synchronous active-low reset
//   bus      hex_display_scanner_if slave (load/value/dp_mask/blank_en in,
//            seg_n/dp_n/an/frame_done out)
module hex_display_scanner
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int REFRESH_DIV   = 50000,
    parameter bit AN_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    hex_display_scanner_if.slave  bus
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(REFRESH_DIV);

    localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = AN_ACTIVE_LOW ? '1 : '0;

    logic [CNT_W-1:0]        presc_q;
    logic [IDX_W-1:0]        idx_q;
    logic [4*NUM_DIGITS-1:0] snap_q;
    logic [NUM_DIGITS-1:0]   dp_q;

    logic                    tick;
    logic                    idx_last;
    logic [3:0]              nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   nz_at_or_above;
    logic [3:0]              cur_nib;
    seg_t                    glyph;
    seg_t                    seg_d;
    logic                    blank_cur;
    logic [NUM_DIGITS-1:0]   an_onehot;
    logic [NUM_DIGITS-1:0]   an_d;

    seg_t                    seg_q;
    logic                    dp_n_q;
    logic [NUM_DIGITS-1:0]   an_q;
    logic                    frame_done_q;

    assign tick     = (presc_q == CNT_LAST);
    assign idx_last = (idx_q == IDX_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + CNT_W'(1);
        end
    end

    // With a single digit idx_last is always true, so the index never moves.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx_q <= '0;
        end else if (tick) begin
            idx_q <= idx_last ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            snap_q <= '0;
            dp_q   <= '0;
        end else if (bus.load) begin
            snap_q <= bus.value;
            dp_q   <= bus.dp_mask;
        end
    end

    // Chain of "some nibble at or above k is nonzero" flags, built from the
    // top digit down. Each stage lives in its own generate scope so the
    // chain does not fold back onto a single vector.
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lz
        logic nz;
        assign nib[k] = snap_q[4*k +: 4];
        if (k == NUM_DIGITS - 1) begin : g_top
            assign nz = |nib[k];
        end else begin : g_mid
            assign nz = (|nib[k]) | g_lz[k+1].nz;
        end
        assign nz_at_or_above[k] = nz;
    end

    assign cur_nib = nib[idx_q];

    seg7_hex_lut u_lut (
        .nibble (cur_nib),
        .seg_n  (glyph)
    );

    // Digit 0 is never blanked so an all-zero value still shows "0".
    assign blank_cur = bus.blank_en && (idx_q != '0) && !nz_at_or_above[idx_q];
    assign seg_d     = blank_cur ? SEG_BLANK : glyph;
    assign an_onehot = NUM_DIGITS'(1) << idx_q;
    assign an_d      = AN_ACTIVE_LOW ? ~an_onehot : an_onehot;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            seg_q        <= SEG_BLANK;
            dp_n_q       <= 1'b1;
            an_q         <= AN_ALL_OFF;
            frame_done_q <= 1'b0;
        end else begin
            seg_q        <= seg_d;
            dp_n_q       <= ~dp_q[idx_q];
            an_q         <= an_d;
            frame_done_q <= tick && idx_last;
        end
    end

    assign bus.seg_n      = seg_q;
    assign bus.dp_n       = dp_n_q;
    assign bus.an         = an_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: doc/hex_display_scanner.md
HEX_DISPLAY_SCANNER -- requirements
Module: hex_display_scanner

Interface
REQ-001 Parameter NUM_DIGITS, default 8, number of hex digits displayed; legal range 1..8.
REQ-002 Parameter REFRESH_DIV, default 50000, clock cycles per digit slot; legal range >=2.
REQ-003 Parameter AN_ACTIVE_LOW, default 1; 1 = anode enables driven active-low.
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 load  input  1  snapshot strobe; value and dp_mask captured on any cycle with load=1.
REQ-007 value  input  4*NUM_DIGITS  number to display; nibble k drives digit k, nibble 0 is least significant.
REQ-008 dp_mask  input  NUM_DIGITS  decimal-point request per digit; 1 = point lit.
REQ-009 blank_en  input  1  1 = leading-zero blanking enabled; sampled live, not snapshotted.
REQ-010 seg_n  output  7  active-low segments; bit 6..0 = g,f,e,d,c,b,a.
REQ-011 dp_n  output  1  active-low decimal point.
REQ-012 an  output  NUM_DIGITS  one-hot digit enable; polarity per AN_ACTIVE_LOW.
REQ-013 frame_done  output  1  one-cycle pulse per completed scan of all digits.

Function
REQ-014 The snapshot register SHALL update on the edge where load=1; the new contents reach seg_n no earlier than the following edge.
REQ-015 The prescaler SHALL count 0..REFRESH_DIV-1 and wrap; the terminal count SHALL produce a one-cycle tick.
REQ-016 On tick, the digit index SHALL advance by 1 and wrap from NUM_DIGITS-1 to 0.
REQ-017 seg_n, dp_n, an SHALL be registered; they reflect the new index one cycle after the tick.
REQ-018 an SHALL be one-hot at the current index, with exactly one digit active outside reset.
REQ-019 seg_n SHALL be the active-low hex glyph of the snapshot nibble at the index: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex).
REQ-020 Digit k>0 SHALL be blank (seg_n=7F) when blank_en=1 and all snapshot nibbles k..NUM_DIGITS-1 are zero.
REQ-021 Digit 0 SHALL never be blanked, so a zero value displays "0".
REQ-022 dp_n SHALL be the inverse of dp_mask[index] and SHALL NOT be affected by blanking.
REQ-023 frame_done SHALL pulse on the tick that wraps the index from NUM_DIGITS-1 to 0.
REQ-024 If load and tick coincide, the newly latched data SHALL be displayed from the following cycle; the index advances normally.
REQ-025 With NUM_DIGITS=1, the index SHALL stay at 0, an SHALL stay fixed, and frame_done SHALL pulse on every tick.

Reset
REQ-026 While reset_n=0 at an edge, the following SHALL be cleared: snapshot to 0, dp snapshot to 0, prescaler to 0, index to 0, frame_done to 0.
REQ-027 During reset, seg_n SHALL be 7F, dp_n 1, and all anodes inactive.
REQ-028 On the first edge after reset_n=1, digit 0 SHALL be active showing "0" (seg_n=40).
REQ-029 Reset asserted mid-scan SHALL take effect on the next edge, with no partial slot completed.

Structure
REQ-030 Package seg_pkg SHALL hold the 16-entry glyph constant table, SEG_BLANK=7'h7F, and the segment bit-order definition.
REQ-031 One sub-module, seg7_hex_lut (4-bit in, 7-bit active-low out, combinational), SHALL be instantiated once on the muxed nibble.
REQ-032 Leading-zero detection SHALL be a generate-built chain of per-digit "nonzero at or above" flags sized by NUM_DIGITS.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, AN_ACTIVE_LOW=1 unless stated)
REQ-033 Release reset -> next cycle an=1110, seg_n=40; index advances every 4 cycles; frame_done pulses every 16 cycles.
REQ-034 load value=16'h00A5, blank_en=1 -> digit0 seg_n=12, digit1 08, digit2 7F, digit3 7F.
REQ-035 Same value with blank_en=0 -> digit2 and digit3 show 40.
REQ-036 load value=16'hF00F, dp_mask=0100 -> per digit 0E,40,40,0E; dp_n=0 only on digit2; no blanking.
REQ-037 Assert load on the tick cycle with value 16'h1234 -> following slot shows the new glyph; no skipped or duplicated index.
REQ-038 Assert reset_n=0 mid-slot at index 2 -> next edge an=1111, seg_n=7F; after release an=1110, seg_n=40.
